// File: rtl/minisys_pkg.sv
// Shared definitions for the Minisys-1A multicycle CPU: PC-write codes,
// instruction-fetch FSM encodings and default reset/exception addresses.
package minisys_pkg;

  // Wpc codes driven by the controller
  localparam logic [1:0] WPC_HOLD   = 2'b00;
  localparam logic [1:0] WPC_INC    = 2'b01;
  localparam logic [1:0] WPC_JUMP   = 2'b10;
  localparam logic [1:0] WPC_BRANCH = 2'b11;

  // Instruction-fetch FSM
  typedef enum logic [1:0] {
    F_IDLE  = 2'b00,  // fetch buffer empty, request goes out next cycle
    F_WAIT  = 2'b01,  // request outstanding on the imem port
    F_VALID = 2'b10   // fetch buffer holds the word for the current pc
  } fetch_state_t;

  localparam logic [31:0] RESET_PC_DEFAULT   = 32'h0000_0000;
  localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'h0000_F000;

endpackage

// File: rtl/ifetch_next_pc.sv
// Next-PC selection for the fetch unit: exception, eret, stall and the
// controller's Wpc code, in that order of priority.
module ifetch_next_pc
  import minisys_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEFAULT
) (
  input  logic [31:0] pc,
  input  logic [25:0] instr_index,  // low 26 bits of IR (jump index / branch imm)
  input  logic [1:0]  wpc,
  input  logic        jrn,
  input  logic [31:0] reg_rs,
  input  logic        exc_req,
  input  logic        eret_req,
  input  logic [31:0] epc,
  input  logic        ir_stall,
  output logic [31:0] next_pc
);

  logic [31:0] branch_off;

  // Sign-extended word offset; pc already points past the branch.
  assign branch_off = {{14{instr_index[15]}}, instr_index[15:0], 2'b00};

  // Priority mux for the PC value written at the next edge
  always_comb begin
    // NOTE: default assignment first so every path drives next_pc and no latch is inferred.
    next_pc = pc;
    if (exc_req) begin
      next_pc = EXC_VECTOR;
    end else if (eret_req) begin
      next_pc = epc & 32'hFFFF_FFFC;
    end else if (!ir_stall) begin
      unique case (wpc)
        WPC_INC:    next_pc = pc + 32'd4;
        WPC_JUMP:   next_pc = jrn ? (reg_rs & 32'hFFFF_FFFC)
                                  : {pc[31:28], instr_index, 2'b00};
        WPC_BRANCH: next_pc = pc + branch_off;
        default:    next_pc = pc;
      endcase
    end
  end

endmodule

// File: rtl/multicycle_ifetch.sv
// Instruction-fetch / PC unit of the Minisys-1A multicycle CPU. Owns PC, IR
// and the link address, and fetches from instruction memory over req/ready.
module multicycle_ifetch
  import minisys_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [1:0]  Wpc,
  input  logic        Wir,
  input  logic        Jrn,
  input  logic [31:0] reg_rs,
  input  logic        exc_req,
  input  logic        eret_req,
  input  logic [31:0] epc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] Instruction,
  output logic [31:0] pc,
  output logic [31:0] link_addr,
  output logic        ir_stall
);

  fetch_state_t state, state_nxt;
  logic         stale;      // pc moved while the request was in flight
  logic [31:0]  req_addr;   // address of the outstanding request
  logic [31:0]  fetch_buf;
  logic [31:0]  next_pc;
  logic [31:0]  ir_word;
  logic         ir_ready;
  logic         pc_change;

  // A word for the current pc is usable now: buffered, or arriving fresh.
  assign ir_ready  = (state == F_VALID) ||
                     ((state == F_WAIT) && imem_ready && !stale);
  assign ir_word   = (state == F_VALID) ? fetch_buf : imem_rdata;
  assign ir_stall  = Wir && !ir_ready;
  assign pc_change = (next_pc != pc);

  ifetch_next_pc #(.EXC_VECTOR(EXC_VECTOR)) u_next_pc (
    .pc          (pc),
    .instr_index (Instruction[25:0]),
    .wpc         (Wpc),
    .jrn         (Jrn),
    .reg_rs      (reg_rs),
    .exc_req     (exc_req),
    .eret_req    (eret_req),
    .epc         (epc),
    .ir_stall    (ir_stall),
    .next_pc     (next_pc)
  );

  // Fetch FSM state register
  always_ff @(posedge clock or posedge reset) begin
    // NOTE: sequential state is assigned with <= so all registers update from pre-edge values.
    if (reset) state <= F_IDLE;
    else       state <= state_nxt;
  end

  // Fetch FSM transitions; a moved pc invalidates any word for the old one
  always_comb begin
    state_nxt = state;
    unique case (state)
      F_IDLE:  state_nxt = F_WAIT;
      F_WAIT:  if (imem_ready) state_nxt = (stale || pc_change) ? F_IDLE : F_VALID;
      F_VALID: if (pc_change)  state_nxt = F_IDLE;
      default: state_nxt = F_IDLE;
    endcase
  end

  // Fetch FSM outputs; the address comes from a register so it is stable during F_WAIT
  always_comb begin
    imem_req  = (state == F_WAIT);
    imem_addr = req_addr;
  end

  // Request address and stale tracking
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      req_addr <= RESET_PC;
      stale    <= 1'b0;
    end else begin
      if (state == F_IDLE) req_addr <= next_pc;
      if (state == F_WAIT) begin
        if (imem_ready)     stale <= 1'b0;
        else if (pc_change) stale <= 1'b1;
      end
    end
  end

  // Fetch buffer capture
  always_ff @(posedge clock) begin
    // NOTE: pure datapath storage, left unreset; F_VALID alone says when it is meaningful.
    if ((state == F_WAIT) && imem_ready) fetch_buf <= imem_rdata;
  end

  // Architectural PC, IR and link address
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc          <= RESET_PC;
      Instruction <= 32'h0;
      link_addr   <= RESET_PC;
    end else begin
      pc <= next_pc;
      if (Wir && ir_ready) begin
        Instruction <= ir_word;
        link_addr   <= pc + 32'd4;
      end
    end
  end

endmodule

// File: tb/tb_multicycle_ifetch.sv
// Self-checking bench for multicycle_ifetch: directed corner sequences, a
// vector table for PC targets, and a randomized run against a
// transaction-level model of PC/IR/link and the fetch protocol.
module tb_multicycle_ifetch;
  import minisys_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic [1:0]  Wpc;
  logic        Wir, Jrn, exc_req, eret_req;
  logic [31:0] reg_rs, epc;
  logic        imem_req, imem_ready;
  logic [31:0] imem_addr, imem_rdata;
  logic [31:0] Instruction, pc, link_addr;
  logic        ir_stall;

  always #5 clock = ~clock;

  multicycle_ifetch dut (
    .clock       (clock),
    .reset       (reset),
    .Wpc         (Wpc),
    .Wir         (Wir),
    .Jrn         (Jrn),
    .reg_rs      (reg_rs),
    .exc_req     (exc_req),
    .eret_req    (eret_req),
    .epc         (epc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rdata  (imem_rdata),
    .Instruction (Instruction),
    .pc          (pc),
    .link_addr   (link_addr),
    .ir_stall    (ir_stall)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory contents: per-address overrides, else a fixed scramble of the address
  logic [31:0] mem_ovr [logic [31:0]];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (mem_ovr.exists(a)) return mem_ovr[a];
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  // Memory responder: ready once the request has waited lat cycles
  int lat     = 1;
  int rsp_cnt = 0;

  // Reference model: architectural values plus fetch transaction bookkeeping
  logic [31:0] m_pc, m_ir, m_link, m_addr;
  logic        m_have;   // word for m_pc already fetched and held
  logic        m_busy;   // request outstanding
  logic        m_stale;  // outstanding request is for an abandoned pc
  logic        last_stall;

  task automatic model_reset();
    m_pc = RESET_PC_DEFAULT; m_ir = 32'h0; m_link = RESET_PC_DEFAULT; m_addr = RESET_PC_DEFAULT;
    m_have = 1'b0; m_busy = 1'b0; m_stale = 1'b0; rsp_cnt = 0;
  endtask

  task automatic idle_inputs();
    Wir = 1'b0; Wpc = WPC_HOLD; Jrn = 1'b0; reg_rs = 32'h0;
    exc_req = 1'b0; eret_req = 1'b0; epc = 32'h0;
  endtask

  // One clock cycle; entered and left 1 time unit after a rising edge
  task automatic step();
    logic [31:0] nxt;
    logic        avail, stall, chg;
    imem_ready = imem_req && (rsp_cnt >= lat);
    imem_rdata = imem_ready ? mem_word(imem_addr) : $urandom();
    #1;
    avail = m_have || (m_busy && imem_ready && !m_stale);
    stall = Wir && !avail;
    last_stall = ir_stall;
    check("imem_req", imem_req, m_busy);
    if (m_busy) check("imem_addr", imem_addr, m_addr);
    check("ir_stall", ir_stall, stall);

    if (exc_req)       nxt = EXC_VECTOR_DEFAULT;
    else if (eret_req) nxt = {epc[31:2], 2'b00};
    else if (stall)    nxt = m_pc;
    else begin
      case (Wpc)
        WPC_INC:    nxt = m_pc + 4;
        WPC_JUMP:   nxt = Jrn ? {reg_rs[31:2], 2'b00} : {m_pc[31:28], m_ir[25:0], 2'b00};
        WPC_BRANCH: nxt = m_pc + 4 * {{16{m_ir[15]}}, m_ir[15:0]};
        default:    nxt = m_pc;
      endcase
    end
    chg = (nxt != m_pc);
    if (Wir && avail) begin
      m_ir   = mem_word(m_pc);
      m_link = m_pc + 4;
    end
    if (m_busy) begin
      if (imem_ready) begin
        m_have  = !m_stale && !chg;
        m_busy  = 1'b0;
        m_stale = 1'b0;
      end else if (chg) begin
        m_stale = 1'b1;
      end
    end else if (m_have) begin
      if (chg) m_have = 1'b0;
    end else begin
      m_busy  = 1'b1;
      m_addr  = nxt;
      m_stale = 1'b0;
    end
    m_pc = nxt;
    if (imem_req && !imem_ready) rsp_cnt++;
    else rsp_cnt = 0;

    @(posedge clock);
    #1;
    check("pc", pc, m_pc);
    check("Instruction", Instruction, m_ir);
    check("link_addr", link_addr, m_link);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_inputs();
    imem_ready = 1'b0;
    imem_rdata = 32'h0;
    @(posedge clock);
    #1;
    reset = 1'b0;
    model_reset();
    check("rst_pc", pc, RESET_PC_DEFAULT);
    check("rst_ir", Instruction, 32'h0);
    check("rst_link", link_addr, RESET_PC_DEFAULT);
    check("rst_req", imem_req, 1'b0);
  endtask

  // Move pc to a via eret, then fetch it with Wir+Wpc=01 until IR loads
  task automatic fetch_at(input logic [31:0] a, input logic [31:0] word);
    int n;
    mem_ovr[a] = word;
    idle_inputs();
    eret_req = 1'b1;
    epc      = a;
    step();
    idle_inputs();
    Wir = 1'b1;
    Wpc = WPC_INC;
    n = 0;
    while (m_pc != a + 4 && n < 20) begin
      step();
      n++;
    end
    if (n >= 20) check("fetch_timeout", pc, a + 4);
    idle_inputs();
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] word;
    logic [1:0]  wpc;
    logic        jrn;
    logic [31:0] rs;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int n, stalls;
    vecs[0] = '{32'h0000_0004, 32'h0800_0010, WPC_JUMP,   1'b0, 32'h0,         32'h0000_0040};
    vecs[1] = '{32'h0000_0004, 32'h0800_0010, WPC_JUMP,   1'b1, 32'h0000_0123, 32'h0000_0120};
    vecs[2] = '{32'h0000_0010, 32'h1000_FFFE, WPC_BRANCH, 1'b0, 32'h0,         32'h0000_000C};
    vecs[3] = '{32'h0000_0010, 32'h1000_0003, WPC_BRANCH, 1'b0, 32'h0,         32'h0000_0020};
    vecs[4] = '{32'h0000_0100, 32'h0000_0020, WPC_INC,    1'b0, 32'h0,         32'h0000_0108};
    vecs[5] = '{32'h0000_0100, 32'h0000_0020, WPC_HOLD,   1'b0, 32'h0,         32'h0000_0104};
    vecs[6] = '{32'h1000_0000, 32'h0A00_0000, WPC_JUMP,   1'b0, 32'h0,         32'h1800_0000};
    vecs[7] = '{32'hFFFF_FFF8, 32'h1000_0001, WPC_BRANCH, 1'b0, 32'h0,         32'h0000_0000};
    vecs[8] = '{32'h0000_0200, 32'h0000_0000, WPC_JUMP,   1'b1, 32'hDEAD_BEEF, 32'hDEAD_BEEC};

    // First fetch, ready one cycle after the request
    do_reset();
    lat = 1;
    mem_ovr[32'h0] = 32'h2001_0005;
    Wir = 1'b1;
    Wpc = WPC_INC;
    n = 0;
    stalls = 0;
    while (m_pc == 32'h0 && n < 20) begin
      step();
      if (last_stall) stalls++;
      n++;
    end
    idle_inputs();
    check("t1_ir", Instruction, 32'h2001_0005);
    check("t1_pc", pc, 32'h4);
    check("t1_link", link_addr, 32'h4);
    check("t1_stall_cycles", stalls, 2);

    // Three-cycle latency with Wir+Wpc=01 held from the first request cycle
    lat = 3;
    n = 0;
    while (!imem_req && n < 10) begin
      step();
      n++;
    end
    check("t2_req_up", imem_req, 1'b1);
    Wir = 1'b1;
    Wpc = WPC_INC;
    n = 0;
    stalls = 0;
    while (m_pc == 32'h4 && n < 20) begin
      step();
      if (last_stall) begin
        stalls++;
        check("t2_pc_hold", pc, 32'h4);
      end
      n++;
    end
    idle_inputs();
    check("t2_stall_cycles", stalls, 3);
    check("t2_pc", pc, 32'h8);
    check("t2_ir", Instruction, mem_word(32'h4));
    check("t2_link", link_addr, 32'h8);

    // Reset while a request is outstanding
    n = 0;
    while (!imem_req && n < 10) begin
      step();
      n++;
    end
    check("t6_req_before", imem_req, 1'b1);
    reset = 1'b1;
    #1;
    check("t6_req_drop", imem_req, 1'b0);
    check("t6_pc_async", pc, RESET_PC_DEFAULT);
    imem_ready = 1'b1;
    imem_rdata = 32'hBAD0_BAD0;
    Wir = 1'b1;
    Wpc = WPC_INC;
    @(posedge clock);
    #1;
    check("t6_no_late_ir", Instruction, 32'h0);
    check("t6_pc_held", pc, RESET_PC_DEFAULT);
    check("t6_req_low", imem_req, 1'b0);
    reset = 1'b0;
    imem_ready = 1'b0;
    idle_inputs();
    model_reset();

    // Exception while a fetch of address 8 is outstanding
    do_reset();
    lat = 3;
    eret_req = 1'b1;
    epc = 32'h8;
    step();
    idle_inputs();
    step();
    check("t5_addr8", imem_addr, 32'h8);
    exc_req = 1'b1;
    step();
    exc_req = 1'b0;
    check("t5_pc_exc", pc, EXC_VECTOR_DEFAULT);
    Wir = 1'b1;
    Wpc = WPC_INC;
    for (int i = 0; i < 10 && imem_req; i++) begin
      check("t5_addr_held", imem_addr, 32'h8);
      step();
    end
    idle_inputs();
    check("t5_req_done", imem_req, 1'b0);
    check("t5_word_dropped", Instruction, 32'h0);
    check("t5_pc_kept", pc, EXC_VECTOR_DEFAULT);
    n = 0;
    while (!imem_req && n < 10) begin
      step();
      n++;
    end
    check("t5_new_addr", imem_addr, EXC_VECTOR_DEFAULT);
    eret_req = 1'b1;
    epc = 32'h200;
    step();
    check("t5_eret", pc, 32'h200);
    exc_req = 1'b1;
    epc = 32'h300;
    step();
    idle_inputs();
    check("t5_exc_wins", pc, EXC_VECTOR_DEFAULT);

    // Vector table: PC targets after a fetched jump/branch/inc/hold
    lat = 1;
    foreach (vecs[i]) begin
      fetch_at(vecs[i].addr, vecs[i].word);
      check("vec_ir", Instruction, vecs[i].word);
      check("vec_link", link_addr, vecs[i].addr + 32'd4);
      Wpc    = vecs[i].wpc;
      Jrn    = vecs[i].jrn;
      reg_rs = vecs[i].rs;
      step();
      idle_inputs();
      check("vec_pc", pc, vecs[i].exp_pc);
    end

    // Randomized run against the model
    for (int i = 0; i < 3000; i++) begin
      lat      = $urandom_range(0, 3);
      Wir      = 1'($urandom_range(0, 1));
      Wpc      = 2'($urandom_range(0, 3));
      Jrn      = 1'($urandom_range(0, 1));
      reg_rs   = $urandom();
      exc_req  = ($urandom_range(0, 15) == 0);
      eret_req = ($urandom_range(0, 15) == 0);
      epc      = $urandom();
      step();
    end
    idle_inputs();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
